// File: rtl/cafe_pkg.sv
// Shared definitions for the coffee machine: coffee-type encodings, dispenser
// states, coin width and the recipe step sequencing.
package cafe_pkg;

   localparam logic [1:0] EXPRESO   = 2'b00;
   localparam logic [1:0] CON_LECHE = 2'b01;
   localparam logic [1:0] CAPUCCINO = 2'b10;
   localparam logic [1:0] MOCACCINO = 2'b11;

   localparam int ANCHO_MONEDA = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CAFE   = 3'd1,
      AGUA   = 3'd2,
      LECHE  = 3'd3,
      CHOCO  = 3'd4,
      VUELTO = 3'd5,
      DONE   = 3'd6
   } estado_t;

   // Next valve step of the recipe; IDLE means the recipe has no more steps.
   function automatic estado_t paso_siguiente(input estado_t actual, input logic [1:0] tipo);
      estado_t sig;
      sig = IDLE;
      case (actual)
         CAFE: begin
            case (tipo)
               EXPRESO:   sig = AGUA;
               CAPUCCINO: sig = AGUA;
               CON_LECHE: sig = LECHE;
               MOCACCINO: sig = CHOCO;
               default:   sig = IDLE;
            endcase
         end
         AGUA:    sig = (tipo == CAPUCCINO) ? LECHE : IDLE;
         CHOCO:   sig = LECHE;
         default: sig = IDLE;
      endcase
      return sig;
   endfunction

endpackage

// File: rtl/temporizador.sv
// Loadable down-counter that stops at zero; 'cero' is registered alongside
// 'valor' so it is valid in the first cycle after a load.
module temporizador
#(
   parameter int ANCHO = 3
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [ANCHO-1:0] carga,
   output logic [ANCHO-1:0] valor,
   output logic             cero
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valor <= '0;
         cero  <= 1'b1;
      end else if (load) begin
         valor <= carga;
         cero  <= (carga == '0);
      end else if (!cero) begin
         valor <= valor - ANCHO'(1);
         cero  <= (valor == ANCHO'(1));
      end else begin
         valor <= valor;
         cero  <= cero;
      end
   end

endmodule

// File: rtl/dispensador.sv
// Beverage dispenser sequencer: runs the timed valve recipe for the captured
// coffee type, pays out the captured change one coin per two cycles, then pulses listo.
module dispensador
   import cafe_pkg::*;
#(
   parameter int T_CAFE  = 4,
   parameter int T_AGUA  = 3,
   parameter int T_LECHE = 2,
   parameter int T_CHOCO = 2
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    iniciarProceso,
   input  logic [1:0]              tipoCafe,
   input  logic [ANCHO_MONEDA-1:0] vuelto,
   output logic                    valvulaCafe,
   output logic                    valvulaAgua,
   output logic                    valvulaLeche,
   output logic                    valvulaChoco,
   output logic                    monedaOut,
   output logic                    ocupado,
   output logic                    listo
);

   localparam int T_MAX_CA = (T_CAFE > T_AGUA) ? T_CAFE : T_AGUA;
   localparam int T_MAX_LC = (T_LECHE > T_CHOCO) ? T_LECHE : T_CHOCO;
   localparam int T_MAX    = (T_MAX_CA > T_MAX_LC) ? T_MAX_CA : T_MAX_LC;
   localparam int ANCHO_T  = $clog2(T_MAX) + 1;

   estado_t                  estado_r;
   estado_t                  estado_s;
   estado_t                  paso_sig_s;
   logic                     prev_inicio_r;
   logic [1:0]               tipo_r;
   logic [ANCHO_MONEDA-1:0]  monedas_r;
   logic                     inicio_s;
   logic                     fin_paso_s;
   logic                     moneda_s;
   logic                     carga_s;
   logic [ANCHO_T-1:0]       valor_carga_s;
   logic [ANCHO_T-1:0]       valor_s;
   logic                     cero_s;

   assign inicio_s   = (estado_r == IDLE) && iniciarProceso && !prev_inicio_r;
   assign paso_sig_s = paso_siguiente(estado_r, tipo_r);
   assign fin_paso_s = cero_s && (valor_s == '0);

   temporizador #(.ANCHO(ANCHO_T)) u_temporizador (
      .clk   (clk),
      .rst   (rst),
      .load  (carga_s),
      .carga (valor_carga_s),
      .valor (valor_s),
      .cero  (cero_s)
   );

   // Next state and next coin-pulse value; a coin pulse is always followed by a low cycle.
   always_comb begin
      estado_s = estado_r;
      moneda_s = 1'b0;
      case (estado_r)
         IDLE: begin
            if (inicio_s) begin
               estado_s = CAFE;
            end else begin
               estado_s = IDLE;
            end
         end
         CAFE, AGUA, LECHE, CHOCO: begin
            if (!fin_paso_s) begin
               estado_s = estado_r;
            end else if (paso_sig_s != IDLE) begin
               estado_s = paso_sig_s;
            end else if (monedas_r != '0) begin
               estado_s = VUELTO;
               moneda_s = 1'b1;
            end else begin
               estado_s = DONE;
            end
         end
         VUELTO: begin
            if (monedaOut) begin
               estado_s = VUELTO;
               moneda_s = 1'b0;
            end else if (monedas_r != '0) begin
               estado_s = VUELTO;
               moneda_s = 1'b1;
            end else begin
               estado_s = DONE;
            end
         end
         DONE:    estado_s = IDLE;
         default: estado_s = IDLE;
      endcase
   end

   // Timer is loaded on entry to each valve step with that step's length minus one.
   always_comb begin
      carga_s       = 1'b0;
      valor_carga_s = '0;
      case (estado_s)
         CAFE:    valor_carga_s = ANCHO_T'(T_CAFE - 1);
         AGUA:    valor_carga_s = ANCHO_T'(T_AGUA - 1);
         LECHE:   valor_carga_s = ANCHO_T'(T_LECHE - 1);
         CHOCO:   valor_carga_s = ANCHO_T'(T_CHOCO - 1);
         default: valor_carga_s = '0;
      endcase
      if ((estado_s != estado_r) && (valor_carga_s == valor_carga_s)) begin
         carga_s = (estado_s == CAFE) || (estado_s == AGUA) ||
                   (estado_s == LECHE) || (estado_s == CHOCO);
      end else begin
         carga_s = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_r      <= IDLE;
         prev_inicio_r <= 1'b1;
         tipo_r        <= 2'b00;
         monedas_r     <= '0;
         valvulaCafe   <= 1'b0;
         valvulaAgua   <= 1'b0;
         valvulaLeche  <= 1'b0;
         valvulaChoco  <= 1'b0;
         monedaOut     <= 1'b0;
         ocupado       <= 1'b0;
         listo         <= 1'b0;
      end else begin
         estado_r      <= estado_s;
         prev_inicio_r <= iniciarProceso;
         if (inicio_s) begin
            tipo_r    <= tipoCafe;
            monedas_r <= vuelto;
         end else if ((estado_r == VUELTO) && monedaOut) begin
            monedas_r <= monedas_r - ANCHO_MONEDA'(1);
         end else begin
            tipo_r    <= tipo_r;
            monedas_r <= monedas_r;
         end
         // Outputs follow the state being entered so they line up with it.
         valvulaCafe  <= (estado_s == CAFE);
         valvulaAgua  <= (estado_s == AGUA);
         valvulaLeche <= (estado_s == LECHE);
         valvulaChoco <= (estado_s == CHOCO);
         monedaOut    <= moneda_s;
         ocupado      <= (estado_s != IDLE);
         listo        <= (estado_s == DONE);
      end
   end

endmodule

// File: tb/tb_dispensador.sv
// Directed bench for dispensador: cycle-by-cycle output traces against
// hand-derived recipe timings with default parameters.
module tb_dispensador;
   import cafe_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       iniciarProceso;
   logic [1:0] tipoCafe;
   logic [3:0] vuelto;
   logic       valvulaCafe, valvulaAgua, valvulaLeche, valvulaChoco;
   logic       monedaOut, ocupado, listo;

   int tests = 0;
   int fails = 0;
   logic [6:0] obs [0:63];

   always #5 clk = ~clk;

   dispensador dut (
      .clk            (clk),
      .rst            (rst),
      .iniciarProceso (iniciarProceso),
      .tipoCafe       (tipoCafe),
      .vuelto         (vuelto),
      .valvulaCafe    (valvulaCafe),
      .valvulaAgua    (valvulaAgua),
      .valvulaLeche   (valvulaLeche),
      .valvulaChoco   (valvulaChoco),
      .monedaOut      (monedaOut),
      .ocupado        (ocupado),
      .listo          (listo)
   );

   function automatic logic [6:0] salidas();
      return {valvulaCafe, valvulaAgua, valvulaLeche, valvulaChoco, monedaOut, listo, ocupado};
   endfunction

   // Records outputs for cycles 1..n after a start edge driven in cycle 0.
   task automatic capture(input int n);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         obs[c] = salidas();
      end
   endtask

   task automatic start_job(input logic [1:0] t, input logic [3:0] k);
      @(negedge clk);
      iniciarProceso = 1'b0;
      @(negedge clk);
      iniciarProceso = 1'b1;
      tipoCafe       = t;
      vuelto         = k;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      iniciarProceso = 1'b0;
      tipoCafe = 2'b00;
      vuelto = 4'd0;
      repeat (2) @(negedge clk);
      tests++;
      if (salidas() !== 7'b0000000) begin
         fails++;
         $display("FAIL reset_outputs got=%b want=%b", salidas(), 7'b0000000);
      end
      rst = 1'b0;
   endtask

   task automatic test_expreso();
      logic [6:0] e;
      start_job(EXPRESO, 4'd2);
      capture(14);
      for (int c = 1; c <= 14; c++) begin
         e = {(c >= 1 && c <= 4), (c >= 5 && c <= 7), 1'b0, 1'b0,
              (c == 8 || c == 10), (c == 12), (c <= 12)};
         tests++;
         if (obs[c] !== e) begin
            fails++;
            $display("FAIL expreso cycle=%0d got=%b want=%b", c, obs[c], e);
         end
      end
   endtask

   task automatic test_mocaccino();
      logic [6:0] e;
      start_job(MOCACCINO, 4'd0);
      capture(11);
      for (int c = 1; c <= 11; c++) begin
         e = {(c <= 4), 1'b0, (c == 7 || c == 8), (c == 5 || c == 6),
              1'b0, (c == 9), (c <= 9)};
         tests++;
         if (obs[c] !== e) begin
            fails++;
            $display("FAIL mocaccino cycle=%0d got=%b want=%b", c, obs[c], e);
         end
      end
   endtask

   task automatic test_start_held_through_reset();
      logic [6:0] e;
      @(negedge clk);
      iniciarProceso = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      capture(5);
      for (int c = 1; c <= 5; c++) begin
         tests++;
         if (obs[c] !== 7'b0000000) begin
            fails++;
            $display("FAIL held_no_start cycle=%0d got=%b want=%b", c, obs[c], 7'b0000000);
         end
      end
      start_job(CON_LECHE, 4'd0);
      capture(8);
      for (int c = 1; c <= 8; c++) begin
         e = {(c <= 4), 1'b0, (c == 5 || c == 6), 1'b0, 1'b0, (c == 7), (c <= 7)};
         tests++;
         if (obs[c] !== e) begin
            fails++;
            $display("FAIL held_then_edge cycle=%0d got=%b want=%b", c, obs[c], e);
         end
      end
   endtask

   task automatic test_busy_inputs_ignored();
      logic [6:0] e;
      start_job(CAPUCCINO, 4'd3);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         obs[c] = salidas();
         if (c == 3) begin
            iniciarProceso = 1'b0;
         end else if (c == 5) begin
            iniciarProceso = 1'b1;
            tipoCafe = EXPRESO;
            vuelto = 4'd5;
         end
      end
      for (int c = 1; c <= 20; c++) begin
         e = {(c <= 4), (c >= 5 && c <= 7), (c == 8 || c == 9), 1'b0,
              (c == 10 || c == 12 || c == 14), (c == 16), (c <= 16)};
         tests++;
         if (obs[c] !== e) begin
            fails++;
            $display("FAIL capuccino_busy cycle=%0d got=%b want=%b", c, obs[c], e);
         end
      end
   endtask

   task automatic test_reset_mid_leche();
      start_job(CON_LECHE, 4'd4);
      capture(5);
      tests++;
      if (obs[5] !== 7'b0010001) begin
         fails++;
         $display("FAIL leche_before_reset got=%b want=%b", obs[5], 7'b0010001);
      end
      rst = 1'b1;
      #1;
      tests++;
      if (salidas() !== 7'b0000000) begin
         fails++;
         $display("FAIL reset_mid_outputs got=%b want=%b", salidas(), 7'b0000000);
      end
      tests++;
      if (dut.estado_r !== IDLE) begin
         fails++;
         $display("FAIL reset_mid_state got=%0d want=%0d", dut.estado_r, IDLE);
      end
      @(negedge clk);
      rst = 1'b0;
      capture(15);
      for (int c = 1; c <= 15; c++) begin
         tests++;
         if (obs[c] !== 7'b0000000) begin
            fails++;
            $display("FAIL reset_mid_after cycle=%0d got=%b want=%b", c, obs[c], 7'b0000000);
         end
      end
   endtask

   task automatic test_vuelto_max();
      logic [6:0] e;
      int pulses;
      pulses = 0;
      start_job(EXPRESO, 4'd15);
      capture(40);
      for (int c = 1; c <= 40; c++) begin
         e = {(c <= 4), (c >= 5 && c <= 7), 1'b0, 1'b0,
              (c >= 8 && c <= 36 && (c % 2 == 0)), (c == 38), (c <= 38)};
         pulses += int'(obs[c][2]);
         tests++;
         if (obs[c] !== e) begin
            fails++;
            $display("FAIL vuelto15 cycle=%0d got=%b want=%b", c, obs[c], e);
         end
      end
      tests++;
      if (pulses != 15) begin
         fails++;
         $display("FAIL vuelto15_count got=%0d want=15", pulses);
      end
   endtask

   initial begin
      test_reset();
      test_expreso();
      test_mocaccino();
      test_start_held_through_reset();
      test_busy_inputs_ignored();
      test_reset_mid_leche();
      test_vuelto_max();
      @(negedge clk);
      iniciarProceso = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dispensador.md
# dispensador

Beverage dispenser sequencer for the coffee machine. It sits downstream of the payment verifier and consumes its `iniciarProceso`, `tipoCafe` and `vuelto` outputs. On a start request it drives the ingredient valves in a fixed, timed recipe for the selected coffee, pays out the change one coin pulse at a time, and signals completion. It is the consumer end of the verifier's start/selection/change interface.

## Interface
Parameters:
- `T_CAFE`, default 4: cycles the coffee valve stays open (≥1)
- `T_AGUA`, default 3: cycles the water valve stays open (≥1)
- `T_LECHE`, default 2: cycles the milk valve stays open (≥1)
- `T_CHOCO`, default 2: cycles the chocolate valve stays open (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `iniciarProceso` in 1: start request (level); a job starts on its rising edge
- `tipoCafe` in 2: 00 expreso, 01 con leche, 10 capuccino, 11 mocaccino
- `vuelto` in 4: change to return, in coin units (0–15)
- `valvulaCafe`, `valvulaAgua`, `valvulaLeche`, `valvulaChoco` out 1 each: valve enables
- `monedaOut` out 1: one-cycle pulse per coin returned
- `ocupado` out 1: high in every non-IDLE state
- `listo` out 1: one-cycle pulse when the job completes

## Operation
- States: IDLE, CAFE, AGUA, LECHE, CHOCO, VUELTO, DONE.
- Start detection:
  - `prevInicio` register, reset value 1; a start occurs when `iniciarProceso` is 1 and `prevInicio` is 0 while in IDLE.
  - A request already high at reset release therefore does not start a job.
- At start, `tipoCafe` and `vuelto` are captured into registers. Inputs are ignored until the machine returns to IDLE. Edges seen while busy are dropped, but `prevInicio` keeps tracking.
- Recipes (steps run back-to-back, each step lasts its parameter in cycles):
  - 00: CAFE → AGUA
  - 01: CAFE → LECHE
  - 10: CAFE → AGUA → LECHE
  - 11: CAFE → CHOCO → LECHE
- Exactly one valve is high per step state. All valves are low in IDLE, VUELTO and DONE.
- VUELTO:
  - For captured change k > 0, emit k pairs of (`monedaOut` high one cycle, low one cycle).
  - If k = 0, skip VUELTO and go straight to DONE.
- DONE lasts one cycle with `listo` = 1, then returns to IDLE.
- Reset values: state IDLE, all outputs 0, captured registers 0, `prevInicio` 1.
- Reset mid-job: all valves and `monedaOut` drop immediately (asynchronous). Remaining coins are not paid.

## Timing
- Start edge seen in cycle N: first step begins at N+1, and `ocupado` is high from N+1 through DONE inclusive.
- Step length is exact. CAFE with `T_CAFE`=4 starts at N+1 and holds the valve for cycles N+1..N+4; the next step starts at N+5. There are no gap cycles.
- The step timer is a down-counter loaded with T−1 on step entry. The step advances when the timer reads 0.
  - Counter width is $clog2 of the maximum parameter + 1.
- Coin counter is 4 bits, loaded with k, and decremented on each high pulse.
- Latency from start to `listo` = 1 + sum of recipe step times + 2k.
- A new start is possible in the first IDLE cycle after DONE, but only on a fresh rising edge.

## Structure
- Shared package `cafe_pkg` holds:
  - the `tipoCafe` encodings (EXPRESO, CON_LECHE, CAPUCCINO, MOCACCINO) as 2-bit constants
  - the state enum
  - the coin unit width (4)
- The verifier uses the same `tipoCafe` constants from this package.
- One sub-module, `temporizador`: a parameterised down-counter with `load`, `valor` and `cero` outputs. It is used for the step timing.
- The FSM and the coin counter stay in `dispensador`.

## Test plan
All scenarios use the default parameters.
- Expreso, `vuelto`=2, start edge at cycle 0:
  - `valvulaCafe` high cycles 1–4, `valvulaAgua` high 5–7
  - `monedaOut` high at 8 and 10
  - `listo` at 12, `ocupado` low at 13
- Mocaccino, `vuelto`=0:
  - CAFE 1–4, CHOCO 5–6, LECHE 7–8
  - no coin pulses, `listo` at 9
- `iniciarProceso` held high through reset release, then held high: no job starts. Drop it low then raise it: the job starts on the next cycle.
- Second edge plus changed `tipoCafe`/`vuelto` during a capuccino job: the job keeps its captured values, and the edge is not replayed after DONE.
- `rst` asserted in the middle of LECHE: all outputs go to 0 immediately, the state is IDLE, and no `listo` is issued.
- `vuelto`=15: exactly 15 `monedaOut` pulses spaced 2 cycles apart, then `listo`.
